// File: rtl/cache_fill_unit_pkg.sv
// Shared definitions for the cache line-fill bus master: states, requester
// encoding, the tag used for line reads and the default geometry constants.
package cache_fill_unit_pkg;

    localparam int DEFAULT_BUS_DATA_WIDTH = 64;
    localparam int DEFAULT_BUS_TAG_WIDTH  = 13;
    localparam int DEFAULT_ADDRESS_SIZE   = 64;
    localparam int DEFAULT_BLOCK_BYTES    = 64;

    localparam int DEFAULT_OFFSET_BITS = $clog2(DEFAULT_BLOCK_BYTES);
    localparam int DEFAULT_BEATS       = DEFAULT_BLOCK_BYTES * 8 / DEFAULT_BUS_DATA_WIDTH;

    // Tag carried by every line read and expected on its response beats.
    localparam logic [12:0] MEMORY_READ_TAG = 13'h0A5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        FILL
    } fill_state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } fill_src_e;

endpackage

// File: rtl/cache_fill_unit_line_assembler.sv
// Collects response beats into one cache line. The line register doubles as
// the visible fill line, so it only changes when a new beat is written.
module line_assembler #(
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_we,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_first,
    output logic                          o_done,
    output logic [BEATS*DATA_WIDTH-1:0]   o_line
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]            r_count;
    logic [BEATS*DATA_WIDTH-1:0] r_line;

    // Beat counter and indexed line write; clear only rewinds the counter so
    // the previous line stays visible until the next burst's first beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_line  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_we) begin
            r_line[int'(r_count) * DATA_WIDTH +: DATA_WIDTH] <= i_data;
            r_count <= (r_count == LAST_BEAT) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_first = (r_count == '0);
    assign o_done  = i_we && (r_count == LAST_BEAT);
    assign o_line  = r_line;

endmodule

// File: rtl/cache_fill_unit.sv
// Miss-handling bus master: arbitrates instruction/data line misses (data
// wins), issues one bus read, assembles the burst and pulses the fill.
module cache_fill_unit
    import cache_fill_unit_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = DEFAULT_BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = DEFAULT_BUS_TAG_WIDTH,
    parameter int ADDRESS_SIZE   = DEFAULT_ADDRESS_SIZE,
    parameter int BLOCK_BYTES    = DEFAULT_BLOCK_BYTES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inst_miss_valid,
    input  logic [ADDRESS_SIZE-1:0]   inst_miss_addr,
    output logic                      inst_miss_ready,
    input  logic                      data_miss_valid,
    input  logic [ADDRESS_SIZE-1:0]   data_miss_addr,
    output logic                      data_miss_ready,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      fill_valid,
    output logic                      fill_src,
    output logic [ADDRESS_SIZE-1:0]   fill_addr,
    output logic [BLOCK_BYTES*8-1:0]  fill_line
);

    localparam int LINE_BEATS = BLOCK_BYTES * 8 / BUS_DATA_WIDTH;
    localparam logic [ADDRESS_SIZE-1:0]  OFFSET_MASK = ADDRESS_SIZE'(BLOCK_BYTES - 1);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG    = BUS_TAG_WIDTH'(MEMORY_READ_TAG);

    fill_state_e             r_state;
    fill_state_e             w_nextState;
    logic [ADDRESS_SIZE-1:0] r_reqAddr;
    logic [ADDRESS_SIZE-1:0] r_fillAddr;
    logic [ADDRESS_SIZE-1:0] w_acceptAddr;
    fill_src_e               r_reqSrc;
    fill_src_e               r_fillSrc;
    fill_src_e               w_acceptSrc;
    logic                    w_accept;
    logic                    w_beatWe;
    logic                    w_first;
    logic                    w_done;
    logic                    w_clear;

    // Arbitration: only IDLE accepts, and a pending data miss always wins.
    always_comb begin
        inst_miss_ready = 1'b0;
        data_miss_ready = 1'b0;
        w_acceptSrc     = SRC_INST;
        w_acceptAddr    = inst_miss_addr & ~OFFSET_MASK;
        if (r_state == IDLE) begin
            if (data_miss_valid) begin
                data_miss_ready = 1'b1;
                w_acceptSrc     = SRC_DATA;
                w_acceptAddr    = data_miss_addr & ~OFFSET_MASK;
            end else begin
                inst_miss_ready = inst_miss_valid;
            end
        end
    end

    assign w_accept = inst_miss_ready | data_miss_ready;
    assign w_beatWe = (r_state == RECV) && bus_respcyc && (bus_resptag == READ_TAG);
    assign w_clear  = (r_state == REQ) && bus_reqack;

    assign bus_respack = w_beatWe;
    assign fill_src    = r_fillSrc;
    assign fill_addr   = r_fillAddr;

    // Next-state decode plus the state-driven bus request and fill pulse.
    always_comb begin
        w_nextState = r_state;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        fill_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_nextState = REQ;
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(r_reqAddr);
                bus_reqtag = READ_TAG;
                if (bus_reqack) w_nextState = RECV;
            end
            RECV: begin
                if (w_done) w_nextState = FILL;
            end
            FILL: begin
                fill_valid  = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register, accepted-request latch, and fill address/source which
    // switch over to the new request only when its first beat lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_reqAddr  <= '0;
            r_reqSrc   <= SRC_INST;
            r_fillAddr <= '0;
            r_fillSrc  <= SRC_INST;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_reqAddr <= w_acceptAddr;
                r_reqSrc  <= w_acceptSrc;
            end
            if (w_beatWe && w_first) begin
                r_fillAddr <= r_reqAddr;
                r_fillSrc  <= r_reqSrc;
            end
        end
    end

    line_assembler #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .BEATS      (LINE_BEATS)
    ) u_lineAssembler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_we    (w_beatWe),
        .i_data  (bus_resp),
        .o_first (w_first),
        .o_done  (w_done),
        .o_line  (fill_line)
    );

endmodule

// File: doc/cache_fill_unit.md
# cache_fill_unit

Miss-handling bus master between the L1 cache (instruction and data sides) and the memory bus. It accepts one line-fill request at a time, issues it on the bus request channel, and collects the burst response beats into a full 64-byte line. It then returns the line to the cache with a one-cycle fill pulse.

## Interface
- Parameters:
- `BUS_DATA_WIDTH`, default 64: bus beat width in bits.
- `BUS_TAG_WIDTH`, default 13: bus tag width in bits.
- `ADDRESS_SIZE`, default 64: physical address width.
- `BLOCK_BYTES`, default 64: cache line size; `BEATS = BLOCK_BYTES*8/BUS_DATA_WIDTH`, which is 8 with the defaults.
- Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `inst_miss_valid`  in  1  instruction-side fill request.
- `inst_miss_addr`  in  ADDRESS_SIZE  miss address; any byte within the line.
- `inst_miss_ready`  out  1  request accepted this cycle when `inst_miss_valid` is also high.
- `data_miss_valid`, `data_miss_addr`, `data_miss_ready`: same as the instruction set, for the data side.
- `bus_reqcyc`  out  1  bus request valid.
- `bus_reqack`  in  1  memory accepts the request.
- `bus_req`  out  BUS_DATA_WIDTH  line-aligned address, zero-extended.
- `bus_reqtag`  out  BUS_TAG_WIDTH  always `MEMORY_READ_TAG`.
- `bus_respcyc`  in  1  response beat valid.
- `bus_respack`  out  1  beat consumed.
- `bus_resp`  in  BUS_DATA_WIDTH  response beat data.
- `bus_resptag`  in  BUS_TAG_WIDTH  response beat tag.
- `fill_valid`  out  1  one-cycle pulse; the line is complete.
- `fill_src`  out  1  requester of the fill: 0 = instruction, 1 = data.
- `fill_addr`  out  ADDRESS_SIZE  line-aligned address of the fill.
- `fill_line`  out  BLOCK_BYTES*8  assembled line.

## Operation
- States are IDLE, REQ, RECV and FILL.
- **IDLE**
  - The ready signals are high only in this state.
  - If `data_miss_valid` is high, the data request wins and `data_miss_ready`=1, `inst_miss_ready`=0.
  - Otherwise `inst_miss_ready` follows `inst_miss_valid`.
  - On a handshake, latch the aligned address (low log2(BLOCK_BYTES) bits cleared) and the source, then go to REQ.
  - Requesters must hold their valid and address stable until they see ready.
- **REQ**
  - `bus_reqcyc`=1, `bus_req`=latched address, `bus_reqtag`=`MEMORY_READ_TAG`. These are held until `bus_reqack` is sampled high.
  - On that edge, go to RECV with the beat counter at 0.
- **RECV**
  - `bus_respack` = `bus_respcyc && bus_resptag==MEMORY_READ_TAG`. This is combinational from the registered state.
  - On each acknowledged edge, beat k is written to `fill_line[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]` and the counter increments.
  - Beats carrying any other tag are neither acked nor stored.
  - After beat `BEATS-1` is captured, go to FILL.
- **FILL**
  - `fill_valid`=1 for exactly one cycle, then go to IDLE.
  - `fill_line`, `fill_addr` and `fill_src` are registers. They hold their values until the next fill's first beat, or until reset.
- Only one outstanding request at a time; no new request is accepted before the fill pulse completes.

## Timing
- Reset:
  - State goes to IDLE and the counter to 0.
  - These outputs go to 0: `fill_valid`, `fill_src`, `fill_addr`, `fill_line`, `bus_reqcyc`, `bus_req`, `bus_reqtag`, `bus_respack`.
  - The ready outputs follow the IDLE rules from the first cycle after reset.
- Reset mid-operation (REQ or RECV): the partial line is discarded, no fill pulse is issued, and state returns to IDLE on the next edge.
- Latency:
  - Handshake at edge 0.
  - `bus_reqcyc` is high from cycle 1.
  - With reqack at edge N and one beat per cycle starting at cycle N+1, `fill_valid` is high in cycle N+1+BEATS.
- Minimum handshake-to-fill latency with defaults: 10 cycles (acknowledge in the first REQ cycle, back-to-back beats).
- Gaps in `bus_respcyc` stall the counter without error.
- `bus_reqack` outside REQ is ignored. `bus_respcyc` outside RECV is not acked.
- Simultaneous `inst_miss_valid` and `data_miss_valid` in IDLE: data is served first. Instruction is accepted in the next IDLE cycle, i.e. the cycle after FILL.

## Structure
- Shared package holds:
  - `MEMORY_READ_TAG`;
  - the `fill_state_e` enum {IDLE, REQ, RECV, FILL};
  - `BLOCK_BYTES`-derived constants (offset width, BEATS);
  - the `fill_src_e` typedef.
- One natural sub-module, `line_assembler`: beat counter plus line shift/indexed register, with clear, write-enable, data-in and done outputs.
- FSM and arbitration stay in `cache_fill_unit`.

## Test plan
- **Instruction fill.** Reset, then inst miss at 0x1234.
  - Required: `bus_req`=0x1200, tag=`MEMORY_READ_TAG`; reqack after 2 cycles.
  - Beats 0x0..0x7 back-to-back give `fill_line` = concatenation with beat 0 in bits [63:0].
  - `fill_src`=0, one-cycle `fill_valid`.
- **Simultaneous requests.** Inst 0x40 and data 0x80 in the same cycle.
  - Required: data served first (`bus_req`=0x80, `fill_src`=1).
  - Instruction accepted immediately after the fill, then `bus_req`=0x40.
- **Stalled beats.** `bus_respcyc` gaps of 3 cycles between each beat.
  - Required: counter holds during gaps, all 8 beats correct, single fill pulse.
- **Foreign tag.** A beat with a wrong tag mid-burst.
  - Required: `bus_respack`=0 for it, not stored, burst still completes with the correct 8 beats.
- **Reset mid-burst.** Reset after 4 beats.
  - Required: no `fill_valid`, all outputs 0, next request completes normally.
- **Back-to-back fills.** Consecutive data misses.
  - Required: `fill_line` stable between fills, latency 10 cycles each with immediate acks.
